// File: rtl/audio_pkg.sv
// Shared types and helpers for the strobe period meter and other strobe consumers.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_t;

  // Largest value an unsigned counter of the given width can hold.
  function automatic int unsigned cnt_max(input int unsigned bitlen);
    return (32'd1 << bitlen) - 32'd1;
  endfunction

endpackage

// File: rtl/strobe_period_meter_rise_detect.sv
// Rising-edge detector for a strobe; with STROBE_SYNC_EN defined the strobe
// first passes a 2-flop synchronizer (adds 2 cycles of edge latency).
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_strobe,
  output logic o_rise
);

  logic w_strobe_q;
  logic r_prev;

`ifdef STROBE_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_strobe;
      r_sync2 <= r_sync1;
    end
  end

  assign w_strobe_q = r_sync2;
`else
  assign w_strobe_q = i_strobe;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_strobe_q;
    end
  end

  assign o_rise = w_strobe_q & ~r_prev;

endmodule

// File: rtl/strobe_period_meter.sv
// Measures cycles between strobe rising edges minus one; valid pulses one cycle
// after the sampled rise. Optional input synchronizer under STROBE_SYNC_EN.
module strobe_period_meter #(
  parameter int BITLEN = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              strobe_in,
  input  logic              meas_en,
  output logic [BITLEN-1:0] period_out,
  output logic              period_valid,
  output logic              period_stable,
  output logic              overflow
);
  import audio_pkg::*;

  localparam logic [BITLEN-1:0] CNT_MAX = BITLEN'(cnt_max(BITLEN));

  logic              w_rise;
  meas_state_t       r_state;
  logic [BITLEN-1:0] r_cnt;
  logic [BITLEN-1:0] r_period;
  logic              r_valid;
  logic              r_stable;
  logic              r_ovf;
  logic              r_have_prev;

  rise_detect u_rise_detect (
    .i_clk    (clk),
    .i_rst_n  (n_rst),
    .i_strobe (strobe_in),
    .o_rise   (w_rise)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_stable    <= 1'b0;
      r_ovf       <= 1'b0;
      r_have_prev <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // Disable wins over a simultaneous rise; period_out is kept.
      if (!meas_en) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_stable    <= 1'b0;
        r_ovf       <= 1'b0;
        r_have_prev <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_cnt       <= '0;
            r_stable    <= 1'b0;
            r_ovf       <= 1'b0;
            r_have_prev <= 1'b0;
            r_state     <= ARM;
          end
          ARM: begin
            if (w_rise) begin
              r_cnt   <= '0;
              r_state <= MEASURE;
            end
          end
          MEASURE: begin
            if (w_rise) begin
              r_period    <= r_cnt;
              r_valid     <= 1'b1;
              r_stable    <= r_have_prev && (r_cnt == r_period);
              r_have_prev <= 1'b1;
              r_ovf       <= 1'b0;
              r_cnt       <= '0;
            end else if (r_cnt == CNT_MAX) begin
              // Gap too long to represent: drop the partial count and re-arm.
              r_ovf       <= 1'b1;
              r_stable    <= 1'b0;
              r_have_prev <= 1'b0;
              r_cnt       <= '0;
              r_state     <= ARM;
            end else begin
              r_cnt <= r_cnt + BITLEN'(1);
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign period_out    = r_period;
  assign period_valid  = r_valid;
  assign period_stable = r_stable;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_strobe_period_meter.sv
// Randomized bench for strobe_period_meter against a timestamp-based reference model.
module tb_strobe_period_meter;

`ifdef STROBE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int BITLEN = 8;
  localparam int MAXP   = (1 << BITLEN) - 1;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              strobe_in;
  logic              meas_en;
  logic [BITLEN-1:0] period_out;
  logic              period_valid;
  logic              period_stable;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  strobe_period_meter #(.BITLEN(BITLEN)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .strobe_in     (strobe_in),
    .meas_en       (meas_en),
    .period_out    (period_out),
    .period_valid  (period_valid),
    .period_stable (period_stable),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: works from the timestamp of the last rise, not a counter.
  int   m_cyc;
  int   m_mode;       // 0 idle, 1 waiting for first rise, 2 measuring
  int   m_last;
  int   m_period;
  bit   m_valid;
  bit   m_stable;
  bit   m_ovf;
  bit   m_have_prev;
  bit   m_hist [0:3];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d", tag, m_cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_period = 0;
    m_valid = 0; m_stable = 0; m_ovf = 0; m_have_prev = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
  endtask

  task automatic model_step(input bit s, input bit e);
    bit rise;
    int gap;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s;
    rise = m_hist[LAT] && !m_hist[LAT+1];
    m_valid = 0;
    if (!e) begin
      m_mode = 0; m_ovf = 0; m_stable = 0; m_have_prev = 0;
    end else if (m_mode == 0) begin
      m_ovf = 0; m_stable = 0; m_have_prev = 0; m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) begin m_last = m_cyc; m_mode = 2; end
    end else begin
      gap = m_cyc - m_last;
      if (rise) begin
        m_stable    = m_have_prev && ((gap - 1) == m_period);
        m_period    = gap - 1;
        m_valid     = 1;
        m_ovf       = 0;
        m_have_prev = 1;
        m_last      = m_cyc;
      end else if (gap - 1 >= MAXP) begin
        m_ovf = 1; m_stable = 0; m_have_prev = 0; m_mode = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("period_out", int'(period_out), m_period);
    chk("period_valid", int'(period_valid), int'(m_valid));
    chk("period_stable", int'(period_stable), int'(m_stable));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  // One clock: drive at the negedge, update model at posedge, compare 1 time unit later.
  task automatic cyc(input bit s, input bit e);
    strobe_in = s;
    meas_en   = e;
    @(posedge clk);
    m_cyc++;
    if (!n_rst) model_reset();
    else        model_step(s, e);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Pulse of given width, repeating every lim+1 cycles; enable drops for 3 cycles at drop_at.
  task automatic pulse(input int lim, input int width, input int drop_at);
    for (int i = 0; i <= lim; i++)
      cyc(i < width, !(drop_at >= 0 && i >= drop_at && i < drop_at + 3));
  endtask

  task automatic async_reset();
    #2 n_rst = 1'b0;
    #1;
    chk("rst_period", int'(period_out), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_stable", int'(period_stable), 0);
    chk("rst_ovf", int'(overflow), 0);
    model_reset();
    @(negedge clk);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    n_rst = 1'b1;
  endtask

  initial begin
    int saved;
    int vcount;
    n_rst = 1'b1; strobe_in = 1'b0; meas_en = 1'b0; m_cyc = 0;
    model_reset();
    @(negedge clk);
    async_reset();

    // Strobe every 6 cycles, reset mid-run, then count valids to see the two-rise arming.
    for (int k = 0; k < 5; k++) pulse(5, 1, -1);
    async_reset();
    vcount = 0;
    for (int i = 0; i < 6 + LAT; i++) begin
      cyc(i == 0, 1'b1);
      vcount += int'(period_valid);
    end
    chk("one_rise_no_valid", vcount, 0);
    for (int k = 0; k < 4; k++) pulse(5, 1, -1);

    // Nominal lim=10.
    for (int k = 0; k < 6; k++) pulse(10, 1, -1);
    for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 1'b1);
    chk("nominal_period", int'(period_out), 10);
    chk("nominal_stable", int'(period_stable), 1);

    // Minimum period then strobe stuck high.
    for (int k = 0; k < 12; k++) pulse(1, 1, -1);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1);
    chk("stuck_high_ovf", int'(overflow), 1);

    // Long gap, then recovery at lim=4.
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) pulse(7, 1, -1);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1);
    chk("gap_ovf", int'(overflow), 1);
    for (int k = 0; k < 5; k++) pulse(4, 2, -1);

    // Period change 10 -> 20.
    for (int k = 0; k < 4; k++) pulse(10, 1, -1);
    for (int k = 0; k < 4; k++) pulse(20, 3, -1);

    // Enable drops on the cycle the DUT sees a rise.
    for (int k = 0; k < 3; k++) pulse(10, 1, -1);
    for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 1'b1);
    saved = int'(period_out);
    for (int i = 0; i < 11 - LAT - 1; i++) cyc(1'b0, 1'b1);
    vcount = 0;
    for (int i = 0; i <= 10; i++) begin
      cyc(i == 0, i < LAT);
      vcount += int'(period_valid);
    end
    chk("drop_no_valid", vcount, 0);
    chk("drop_hold_period", int'(period_out), saved);
    chk("drop_ovf", int'(overflow), 0);
    for (int k = 0; k < 4; k++) pulse(6, 1, -1);

    // Randomized: mixed periods, widths, near-max gaps and enable drops.
    for (int k = 0; k < 120; k++) begin
      int lim;
      int width;
      int drop;
      lim   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262))
                                          : int'($urandom_range(1, 30));
      width = int'($urandom_range(1, (lim < 3) ? lim : 3));
      drop  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, lim)) : -1;
      pulse(lim, width, drop);
      if ($urandom_range(0, 39) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/strobe_period_meter.md
Name: strobe_period_meter

Overview:
- Measures the spacing of a periodic strobe, such as a divided-clock tick, and recovers the divider limit that produced it.
- A pulse every L+1 clk cycles reports period_out = L.
- Sits on the consuming end of clock-divider strobes; used for self-check of sample-rate ticks and for closed-loop limit calibration.
- Rising-edge based; runs in the same clock domain as the strobe source unless the sync option is compiled in.

Parameters:
- BITLEN, 8: width of the internal counter and of period_out. Maximum reportable period is 2^BITLEN-1.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- strobe_in  input  1  strobe to measure; only rising edges are significant.
- meas_en  input  1  measurement enable; low forces IDLE.
- period_out  output  BITLEN  last measured period, i.e. cycles between rising edges minus 1.
- period_valid  output  1  one-cycle pulse when period_out is updated.
- period_stable  output  1  high while the two most recent measurements are equal.
- overflow  output  1  sticky; a gap exceeded the counter range.

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous and active-low.
  - Reset drives period_out=0, period_valid=0, period_stable=0, overflow=0, cnt=0, edge history=0, state=IDLE.
- Edge detect:
  - rise = strobe_q & ~strobe_prev, where strobe_prev is registered every cycle in all states.
  - A constantly-high strobe yields no edges. A period of 0 (lim=0) is therefore unmeasurable and ends in overflow.
- State IDLE:
  - cnt=0; period_valid=0; overflow and period_stable cleared; period_out holds its value.
  - meas_en=1 -> ARM.
- State ARM:
  - Waits for the first rise. On rise: cnt<=0 -> MEASURE. No valid is issued.
- State MEASURE:
  - On rise: period_out<=cnt, period_valid<=1 on the next cycle, cnt<=0, overflow<=0.
  - period_stable<=(cnt==period_out) when a previous measurement exists since ARM, else 0.
  - With no rise: if cnt<max, cnt<=cnt+1.
  - If cnt==max and no rise: overflow<=1, period_stable<=0, cnt<=0 -> ARM. The partial measurement is discarded.
  - A rise in the same cycle as cnt==max reports max normally; overflow is not set.
- Deassertion of meas_en:
  - meas_en=0 in any state -> IDLE on the next edge. This has priority over a simultaneous rise, so no valid is issued.
- Latency: period_valid asserts 1 cycle after the clock edge on which rise is sampled (registered output).
- Arithmetic:
  - Unsigned.
  - Counter saturates logic at max and never wraps silently.
- Reset mid-operation: immediate return to reset values; no partial result is reported.

Optional Feature:
- Macro: STROBE_SYNC_EN.
- Defined:
  - strobe_in passes through a 2-flop synchronizer before edge detect; strobe_q = second flop.
  - Edge-detect latency increases by 2 cycles; reported periods are unchanged.
  - Synchronizer flops reset to 0.
- Undefined:
  - strobe_q = strobe_in directly.
  - No extra latency; the source must be synchronous to clk.

Decomposition:
- Shared package (audio_pkg):
  - typedef enum logic [1:0] meas_state_t {IDLE, ARM, MEASURE}.
  - Localparam for counter max derived from BITLEN, via a function in the package.
- One sub-module, rise_detect:
  - Optional sync under STROBE_SYNC_EN, plus prev-flop and rise pulse output.
  - Reusable by other strobe consumers.

Test Plan:
- Reset and idle:
  - Stimulus: n_rst low mid-run with meas_en=1, strobe every 6 cycles.
  - Required: all outputs 0 asynchronously; after release, first valid occurs only after two rises.
- Nominal period:
  - Stimulus: BITLEN=8, meas_en=1, 1-cycle pulse every 11 cycles (lim=10).
  - Required: period_out=10 on each valid; period_stable=1 from the second valid onward.
- Minimum period:
  - Stimulus: strobe alternating 1/0 each cycle.
  - Required: period_out=1 every 2 cycles.
  - Then: strobe held high -> no valid; overflow=1 exactly 256 cycles after the last rise.
- Overflow and recovery:
  - Stimulus: gap of 300 cycles.
  - Required: overflow=1, state ARM.
  - Then: pulses every 5 cycles -> overflow clears on the first valid with period_out=4; period_stable=0 on that valid.
- Period change:
  - Stimulus: lim switches 10->20 mid-stream.
  - Required: first valid after the switch shows 20 with period_stable=0; the next shows 20 with period_stable=1.
- Enable drop:
  - Stimulus: meas_en=0 on the same cycle as a rise.
  - Required: no valid; state IDLE; period_out holds its old value; overflow=0.
  - Re-enable: ARM before any new report.
  - With STROBE_SYNC_EN: identical values, valid pulses shifted 2 cycles later.
